// File: rtl/lsu_pkg.sv
// Shared LSU definitions: access-size encodings, FSM state enum, and the
// byte-lane mask helper used by the initiator and later cache work.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    // op[2] selects zero-extension for loads
    localparam int OP_UNS_BIT = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } lsu_state_e;

    // Lanes touched by a 1/2/4/8-byte access at byte offset off; lanes past 7 drop off.
    function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] off);
        logic [15:0] m;
        m = ((16'd1 << (5'd1 << size)) - 16'd1) << off;
        return m[7:0];
    endfunction

endpackage

// File: rtl/lsu_mem_initiator_if.sv
// Execute-side, memory-data-port and writeback handshakes of the LSU initiator.
// master = the initiator itself, slave = its environment.
interface lsu_mem_initiator_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_bits_addr;
    logic [63:0] in_bits_wdata;
    logic [2:0]  in_bits_op;
    logic        in_bits_wen;
    logic [4:0]  in_bits_rd;

    logic        mem_req_valid;
    logic [31:0] mem_req_bits_addr;
    logic [7:0]  mem_req_bits_mask;
    logic [2:0]  mem_req_bits_op;
    logic [63:0] mem_req_bits_wdata;
    logic        mem_req_bits_memen;
    logic        mem_req_bits_wen;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_bits_rdata;

    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_bits_rdata;
    logic [4:0]  out_bits_rd;
    logic        out_bits_err;

    modport master (
        input  in_valid, in_bits_addr, in_bits_wdata, in_bits_op, in_bits_wen, in_bits_rd,
        output in_ready,
        output mem_req_valid, mem_req_bits_addr, mem_req_bits_mask, mem_req_bits_op,
               mem_req_bits_wdata, mem_req_bits_memen, mem_req_bits_wen,
        input  mem_resp_valid, mem_resp_bits_rdata,
        output out_valid, out_bits_rdata, out_bits_rd, out_bits_err,
        input  out_ready
    );

    modport slave (
        output in_valid, in_bits_addr, in_bits_wdata, in_bits_op, in_bits_wen, in_bits_rd,
        input  in_ready,
        input  mem_req_valid, mem_req_bits_addr, mem_req_bits_mask, mem_req_bits_op,
               mem_req_bits_wdata, mem_req_bits_memen, mem_req_bits_wen,
        output mem_resp_valid, mem_resp_bits_rdata,
        input  out_valid, out_bits_rdata, out_bits_rd, out_bits_err,
        output out_ready
    );

endinterface

// File: rtl/lsu_load_align.sv
// Combinational load aligner: shifts the addressed bytes of a doubleword down
// to bit 0 and sign/zero-extends them according to size and op[2].
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [63:0] rdata,
    input  logic [2:0]  offset,
    input  logic [2:0]  op,
    output logic [63:0] data
);

    logic [63:0] shifted;
    logic        sx;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        sx      = ~op[OP_UNS_BIT];
        data    = shifted;
        case (op[1:0])
            SZ_B:    data = {{56{sx & shifted[7]}},  shifted[7:0]};
            SZ_H:    data = {{48{sx & shifted[15]}}, shifted[15:0]};
            SZ_W:    data = {{32{sx & shifted[31]}}, shifted[31:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Single-outstanding load/store initiator for the memory data port.
// Optional: define LSU_MISALIGN_TRAP_EN to fault misaligned accesses without a request.
module lsu_mem_initiator
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clock,
    input  logic                 reset,
    lsu_mem_initiator_if.master  io
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_e  state, state_nxt;
    logic [31:0] addr_q;
    logic [63:0] wdata_q;
    logic [2:0]  op_q;
    logic        wen_q;
    logic [CW-1:0] cnt, cnt_inc;
    logic        timeout;
    logic        misalign;
    logic [63:0] ld_data;
    logic [63:0] out_rdata_q;
    logic [4:0]  out_rd_q;
    logic        out_err_q;
    logic        is_req;

`ifdef LSU_MISALIGN_TRAP_EN
    logic [3:0] align_m;
    assign align_m  = (4'd1 << io.in_bits_op[1:0]) - 4'd1;
    assign misalign = |(io.in_bits_addr[2:0] & align_m[2:0]);
`else
    assign misalign = 1'b0;
`endif

    assign cnt_inc = cnt + CW'(1);
    // Fires on the TIMEOUT_CYCLES-th WAIT cycle, counting the entry cycle as the first.
    assign timeout = (cnt_inc == CW'(TIMEOUT_CYCLES));

    lsu_load_align u_align (
        .rdata  (io.mem_resp_bits_rdata),
        .offset (addr_q[2:0]),
        .op     (op_q),
        .data   (ld_data)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (io.in_valid) state_nxt = misalign ? S_RESP : S_REQ;
            S_REQ:  state_nxt = io.mem_resp_valid ? S_RESP : S_WAIT;
            S_WAIT: if (io.mem_resp_valid || timeout) state_nxt = S_RESP;
            S_RESP: if (io.out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= S_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            op_q        <= '0;
            wen_q       <= 1'b0;
            cnt         <= '0;
            out_rdata_q <= '0;
            out_rd_q    <= '0;
            out_err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: if (io.in_valid) begin
                    addr_q      <= io.in_bits_addr;
                    wdata_q     <= io.in_bits_wdata;
                    op_q        <= io.in_bits_op;
                    wen_q       <= io.in_bits_wen;
                    out_rd_q    <= io.in_bits_rd;
                    out_err_q   <= misalign;
                    out_rdata_q <= '0;
                end
                S_REQ: begin
                    cnt <= '0;
                    if (io.mem_resp_valid) begin
                        out_rdata_q <= wen_q ? 64'd0 : ld_data;
                        out_err_q   <= 1'b0;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt_inc;
                    // A response arriving on the timeout cycle still wins.
                    if (io.mem_resp_valid) begin
                        out_rdata_q <= wen_q ? 64'd0 : ld_data;
                        out_err_q   <= 1'b0;
                    end else if (timeout) begin
                        out_rdata_q <= '0;
                        out_err_q   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign is_req = (state == S_REQ);

    // Request fields read as zero outside the REQ cycle.
    assign io.in_ready           = (state == S_IDLE);
    assign io.mem_req_valid      = is_req;
    assign io.mem_req_bits_addr  = is_req ? addr_q : 32'd0;
    assign io.mem_req_bits_mask  = is_req ? lane_mask(op_q[1:0], addr_q[2:0]) : 8'd0;
    assign io.mem_req_bits_op    = is_req ? op_q : 3'd0;
    assign io.mem_req_bits_wdata = is_req ? (wdata_q << {addr_q[2:0], 3'b000}) : 64'd0;
    assign io.mem_req_bits_memen = is_req;
    assign io.mem_req_bits_wen   = is_req & wen_q;

    assign io.out_valid      = (state == S_RESP);
    assign io.out_bits_rdata = out_rdata_q;
    assign io.out_bits_rd    = out_rd_q;
    assign io.out_bits_err   = out_err_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed bench for lsu_mem_initiator with TIMEOUT_CYCLES=4; expected values
// are hand-computed constants.
module tb_lsu_mem_initiator;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    lsu_mem_initiator_if bus ();

    lsu_mem_initiator #(.TIMEOUT_CYCLES(4)) dut (
        .clock (clock),
        .reset (reset),
        .io    (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic [63:0] wd, input logic [2:0] op,
                        input logic wen, input logic [4:0] rd);
        bus.in_valid      = 1'b1;
        bus.in_bits_addr  = a;
        bus.in_bits_wdata = wd;
        bus.in_bits_op    = op;
        bus.in_bits_wen   = wen;
        bus.in_bits_rd    = rd;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic respond(input logic [63:0] rd);
        bus.mem_resp_valid      = 1'b1;
        bus.mem_resp_bits_rdata = rd;
        tick();
        bus.mem_resp_valid = 1'b0;
    endtask

    task automatic pop();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0; bus.in_bits_addr = '0; bus.in_bits_wdata = '0;
        bus.in_bits_op = '0; bus.in_bits_wen = 1'b0; bus.in_bits_rd = '0;
        bus.mem_resp_valid = 1'b0; bus.mem_resp_bits_rdata = '0; bus.out_ready = 1'b0;
        reset = 1'b0;
        repeat (3) tick();
        chk("rst_in_ready",  bus.in_ready, 1);
        chk("rst_req_valid", bus.mem_req_valid, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_err",       bus.out_bits_err, 0);
        chk("rst_rdata",     bus.out_bits_rdata, 0);
        chk("rst_mask",      bus.mem_req_bits_mask, 0);
        reset = 1'b1;
        tick();

        // LD, response in the REQ cycle
        send(32'h8000_0008, 64'd0, 3'd3, 1'b0, 5'd5);
        chk("ld_req_valid", bus.mem_req_valid, 1);
        chk("ld_mask",      bus.mem_req_bits_mask, 8'hFF);
        chk("ld_addr",      bus.mem_req_bits_addr, 32'h8000_0008);
        chk("ld_op",        bus.mem_req_bits_op, 3);
        chk("ld_memen",     bus.mem_req_bits_memen, 1);
        chk("ld_wen",       bus.mem_req_bits_wen, 0);
        chk("ld_out_early", bus.out_valid, 0);
        respond(64'h1122_3344_5566_7788);
        chk("ld_out_valid", bus.out_valid, 1);
        chk("ld_rdata",     bus.out_bits_rdata, 64'h1122_3344_5566_7788);
        chk("ld_rd",        bus.out_bits_rd, 5);
        chk("ld_err",       bus.out_bits_err, 0);
        chk("ld_in_ready",  bus.in_ready, 0);
        pop();
        chk("ld_back_idle", bus.in_ready, 1);
        chk("ld_out_clr",   bus.out_valid, 0);

        // LB / LBU, response 3 cycles after the request
        for (int u = 0; u < 2; u++) begin
            send(32'h8000_0003, 64'd0, (u == 0) ? 3'd0 : 3'd4, 1'b0, 5'd3);
            chk("lb_mask", bus.mem_req_bits_mask, 8'h08);
            tick();
            chk("lb_wait_req", bus.mem_req_valid, 0);
            tick();
            tick();
            chk("lb_wait_out", bus.out_valid, 0);
            respond(64'h1122_3344_8066_7788);
            chk("lb_out_valid", bus.out_valid, 1);
            chk(u == 0 ? "lb_rdata" : "lbu_rdata", bus.out_bits_rdata,
                (u == 0) ? 64'hFFFF_FFFF_FFFF_FF80 : 64'h80);
            pop();
        end

        // SH at lane 6
        send(32'h8000_0006, 64'hBEEF, 3'd1, 1'b1, 5'd7);
        chk("sh_mask",  bus.mem_req_bits_mask, 8'hC0);
        chk("sh_wdata", bus.mem_req_bits_wdata, 64'hBEEF_0000_0000_0000);
        chk("sh_wen",   bus.mem_req_bits_wen, 1);
        respond(64'hDEAD_BEEF_DEAD_BEEF);
        chk("sh_out_valid", bus.out_valid, 1);
        chk("sh_rdata",     bus.out_bits_rdata, 0);
        chk("sh_rd",        bus.out_bits_rd, 7);
        pop();

        // Timeout: no response, RESP after 4 WAIT cycles
        send(32'h8000_0010, 64'd0, 3'd2, 1'b0, 5'd9);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("to_wait_out", bus.out_valid, 0);
            chk("to_wait_rdy", bus.in_ready, 0);
            tick();
        end
        chk("to_out_valid", bus.out_valid, 1);
        chk("to_err",       bus.out_bits_err, 1);
        chk("to_rdata",     bus.out_bits_rdata, 0);
        chk("to_rd",        bus.out_bits_rd, 9);
        pop();
        respond(64'h1234);
        chk("late_resp_idle", bus.in_ready, 1);
        chk("late_resp_out",  bus.out_valid, 0);

        // Writeback stall: outputs held, no new request accepted
        send(32'h8000_0002, 64'd0, 3'd1, 1'b0, 5'd12);
        respond(64'h0000_0000_1234_0000);
        bus.in_valid = 1'b1;
        bus.in_bits_addr = 32'h8000_0000; bus.in_bits_op = 3'd3; bus.in_bits_wen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_out_valid", bus.out_valid, 1);
            chk("stall_rdata",     bus.out_bits_rdata, 64'h1234);
            chk("stall_rd",        bus.out_bits_rd, 12);
            chk("stall_in_ready",  bus.in_ready, 0);
            chk("stall_req",       bus.mem_req_valid, 0);
            tick();
        end
        bus.in_valid = 1'b0;
        pop();
        chk("stall_done", bus.in_ready, 1);

        // LW at offset 2
        send(32'h8000_0002, 64'd0, 3'd2, 1'b0, 5'd4);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("mis_no_req",   bus.mem_req_valid, 0);
        chk("mis_out_valid", bus.out_valid, 1);
        chk("mis_err",      bus.out_bits_err, 1);
        chk("mis_rdata",    bus.out_bits_rdata, 0);
`else
        chk("lw2_req_valid", bus.mem_req_valid, 1);
        chk("lw2_mask",      bus.mem_req_bits_mask, 8'h3C);
        respond(64'h0000_8765_4321_0000);
        chk("lw2_rdata",     bus.out_bits_rdata, 64'hFFFF_FFFF_8765_4321);
        chk("lw2_err",       bus.out_bits_err, 0);
`endif
        pop();

        // Reset while waiting drops the op
        send(32'h8000_0000, 64'd0, 3'd3, 1'b0, 5'd1);
        tick();
        chk("rstw_in_wait", bus.in_ready, 0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("rstw_idle",      bus.in_ready, 1);
        chk("rstw_out_valid", bus.out_valid, 0);
        chk("rstw_err",       bus.out_bits_err, 0);
        respond(64'hFFFF);
        for (int i = 0; i < 3; i++) begin
            chk("rstw_no_out", bus.out_valid, 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
